// File: rtl/axi_cache_bridge_if.sv
// ============================================================================
// Module      : axi_cache_bridge_if
// Description : Bus bundle for axi_cache_bridge. It groups the AXI3 master
//               channels (AR/R/AW/W/B) with the icache read port and the
//               dcache read/write ports.
//               - modport master : the bridge's view. It drives AXI requests
//                                  and cache responses.
//               - modport slave  : the environment's view (caches plus the
//                                  AXI fabric).
// Parameters  : LINE_WORDS - 32-bit words per cache line. This sets the
//                            width of dcache_wr_data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface axi_cache_bridge_if #(
  parameter int LINE_WORDS = 4
);
  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  // AXI write address channel
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  // AXI write data channel
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  // AXI write response channel
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  // icache read port
  logic        icache_rd_req;
  logic [2:0]  icache_rd_type;
  logic [31:0] icache_rd_addr;
  logic        icache_rd_rdy;
  logic        icache_ret_valid;
  logic        icache_ret_last;
  logic [31:0] icache_ret_data;

  // dcache read port
  logic        dcache_rd_req;
  logic [2:0]  dcache_rd_type;
  logic [31:0] dcache_rd_addr;
  logic        dcache_rd_rdy;
  logic        dcache_ret_valid;
  logic        dcache_ret_last;
  logic [31:0] dcache_ret_data;

  // dcache write port (word 0 in bits [31:0])
  logic                    dcache_wr_req;
  logic [2:0]              dcache_wr_type;
  logic [31:0]             dcache_wr_addr;
  logic [3:0]              dcache_wr_wstrb;
  logic [32*LINE_WORDS-1:0] dcache_wr_data;
  logic                    dcache_wr_rdy;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    input  icache_rd_req, icache_rd_type, icache_rd_addr,
    output icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    input  dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    output dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    input  dcache_wr_req, dcache_wr_type, dcache_wr_addr, dcache_wr_wstrb, dcache_wr_data,
    output dcache_wr_rdy
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    output icache_rd_req, icache_rd_type, icache_rd_addr,
    input  icache_rd_rdy, icache_ret_valid, icache_ret_last, icache_ret_data,
    output dcache_rd_req, dcache_rd_type, dcache_rd_addr,
    input  dcache_rd_rdy, dcache_ret_valid, dcache_ret_last, dcache_ret_data,
    output dcache_wr_req, dcache_wr_type, dcache_wr_addr, dcache_wr_wstrb, dcache_wr_data,
    input  dcache_wr_rdy
  );

endinterface

`default_nettype wire

// File: rtl/axi_cache_bridge.sv
// ============================================================================
// Module      : axi_cache_bridge
// Description : Bridges the icache read port and the dcache read/write ports
//               onto a single AXI3 master.
//               - Reads: up to one outstanding read. A line read uses an
//                 INCR burst. dcache has strict priority over icache.
//               - Writes: up to one outstanding write, held in a full-line
//                 buffer and written back as a burst.
//               - A read whose line matches the buffered (or incoming) write
//                 line is stalled until the B response retires the buffer.
// Ports       : aclk    - clock
//               aresetn - synchronous active-low reset
//               bus     - axi_cache_bridge_if.master (AXI + cache ports)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_cache_bridge #(
  parameter int LINE_WORDS = 4
) (
  input  wire logic            aclk,
  input  wire logic            aresetn,
  axi_cache_bridge_if.master   bus
);

  localparam int         OFS_W      = $clog2(LINE_WORDS * 4);
  localparam logic [7:0] C_LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BUSY = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Burst length and size decoded from the cache request type.
  function automatic logic [7:0] f_len(input logic [2:0] typ);
    return typ[2] ? C_LINE_LEN : 8'd0;
  endfunction

  function automatic logic [2:0] f_size(input logic [2:0] typ);
    return typ[2] ? 3'b010 : {1'b0, typ[1:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  rd_state_t              r_rd_state;
  logic [3:0]             r_arid;
  logic [31:0]            r_araddr;
  logic [7:0]             r_arlen;
  logic [2:0]             r_arsize;
  logic                   r_arvalid;
  logic                   r_rready;

  wr_state_t              r_wr_state;
  logic [31:0]            r_awaddr;
  logic [7:0]             r_awlen;
  logic [2:0]             r_awsize;
  logic                   r_awvalid;
  logic                   r_wvalid;
  logic                   r_bready;
  logic [32*LINE_WORDS-1:0] r_line;
  logic [3:0]             r_wstrb;
  logic                   r_is_line;
  logic [7:0]             r_beat;
  logic                   r_aw_done;
  logic                   r_w_done;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                   w_wr_rdy;
  logic                   w_wr_accept;
  logic                   w_wbuf_valid;
  logic [31-OFS_W:0]      w_wr_tag;
  logic                   w_haz_d;
  logic                   w_haz_i;
  logic                   w_d_rdy;
  logic                   w_i_rdy;
  logic                   w_rbeat;
  logic                   w_aw_fire;
  logic                   w_w_fire;
  logic                   w_wlast;
  logic                   w_unused;

  assign w_wr_rdy     = (r_wr_state == W_IDLE);
  assign w_wr_accept  = bus.dcache_wr_req & w_wr_rdy;
  assign w_wbuf_valid = (r_wr_state != W_IDLE);

  // A write being accepted this cycle already owns its line. This closes the
  // window where a read of that line could slip past in the same cycle.
  assign w_wr_tag = w_wr_accept ? bus.dcache_wr_addr[31:OFS_W] : r_awaddr[31:OFS_W];
  assign w_haz_d  = (w_wbuf_valid | w_wr_accept) & (bus.dcache_rd_addr[31:OFS_W] == w_wr_tag);
  assign w_haz_i  = (w_wbuf_valid | w_wr_accept) & (bus.icache_rd_addr[31:OFS_W] == w_wr_tag);

  assign w_d_rdy = (r_rd_state == R_IDLE) & bus.dcache_rd_req & ~w_haz_d;
  assign w_i_rdy = (r_rd_state == R_IDLE) & bus.icache_rd_req & ~bus.dcache_rd_req & ~w_haz_i;

  // rready is always high in R_DATA, so every rvalid there is a beat.
  assign w_rbeat = (r_rd_state == R_DATA) & bus.rvalid;

  assign w_aw_fire = r_awvalid & bus.awready;
  assign w_w_fire  = r_wvalid & bus.wready;
  assign w_wlast   = (r_beat == r_awlen);

  assign w_unused = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.arid    = r_arid;
  assign bus.araddr  = r_araddr;
  assign bus.arlen   = r_arlen;
  assign bus.arsize  = r_arsize;
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = r_arvalid;
  assign bus.rready  = r_rready;

  assign bus.awid    = 4'd1;
  assign bus.awaddr  = r_awaddr;
  assign bus.awlen   = r_awlen;
  assign bus.awsize  = r_awsize;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = r_awvalid;

  assign bus.wid    = 4'd1;
  assign bus.wdata  = r_line[31:0];
  assign bus.wstrb  = r_is_line ? 4'b1111 : r_wstrb;
  assign bus.wlast  = w_wlast;
  assign bus.wvalid = r_wvalid;
  assign bus.bready = r_bready;

  assign bus.icache_rd_rdy    = w_i_rdy;
  assign bus.icache_ret_valid = w_rbeat & ~r_arid[0];
  assign bus.icache_ret_last  = w_rbeat & ~r_arid[0] & bus.rlast;
  assign bus.icache_ret_data  = bus.rdata;

  assign bus.dcache_rd_rdy    = w_d_rdy;
  assign bus.dcache_ret_valid = w_rbeat & r_arid[0];
  assign bus.dcache_ret_last  = w_rbeat & r_arid[0] & bus.rlast;
  assign bus.dcache_ret_data  = bus.rdata;

  assign bus.dcache_wr_rdy = w_wr_rdy;

  // --------------------------------------------------------------------------
  // Read FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_state <= R_IDLE;
      r_arid     <= 4'd0;
      r_araddr   <= 32'd0;
      r_arlen    <= 8'd0;
      r_arsize   <= 3'd0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_d_rdy) begin
            r_arid     <= 4'd1;
            r_araddr   <= bus.dcache_rd_addr;
            r_arlen    <= f_len(bus.dcache_rd_type);
            r_arsize   <= f_size(bus.dcache_rd_type);
            r_arvalid  <= 1'b1;
            r_rd_state <= R_ADDR;
          end else if (w_i_rdy) begin
            r_arid     <= 4'd0;
            r_araddr   <= bus.icache_rd_addr;
            r_arlen    <= f_len(bus.icache_rd_type);
            r_arsize   <= f_size(bus.icache_rd_type);
            r_arvalid  <= 1'b1;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (bus.arready) begin
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b1;
            r_rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid && bus.rlast) begin
            r_rready   <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write FSM. The line buffer shifts down one word per W beat, so wdata is
  // always the low word.
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_awaddr   <= 32'd0;
      r_awlen    <= 8'd0;
      r_awsize   <= 3'd0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_line     <= '0;
      r_wstrb    <= 4'd0;
      r_is_line  <= 1'b0;
      r_beat     <= 8'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_wr_accept) begin
            r_awaddr   <= bus.dcache_wr_addr;
            r_awlen    <= f_len(bus.dcache_wr_type);
            r_awsize   <= f_size(bus.dcache_wr_type);
            r_line     <= bus.dcache_wr_data;
            r_wstrb    <= bus.dcache_wr_wstrb;
            r_is_line  <= bus.dcache_wr_type[2];
            r_beat     <= 8'd0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_awvalid  <= 1'b1;
            r_wvalid   <= 1'b1;
            r_wr_state <= W_BUSY;
          end
        end
        W_BUSY: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_beat <= r_beat + 8'd1;
            r_line <= r_line >> 32;
            if (w_wlast) begin
              r_wvalid <= 1'b0;
              r_w_done <= 1'b1;
            end
          end
          // Each channel may finish in an earlier cycle or in this one.
          if ((r_aw_done | w_aw_fire) && (r_w_done | (w_w_fire & w_wlast))) begin
            r_bready   <= 1'b1;
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            r_bready   <= 1'b0;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_cache_bridge.sv
// ============================================================================
// Module      : tb_axi_cache_bridge
// Description : Directed self-checking bench for axi_cache_bridge
//               (LINE_WORDS = 4). The bench drives the cache ports and plays
//               the AXI slave by hand, cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_cache_bridge;

  logic aclk;
  logic aresetn;
  int   n_checks;
  int   n_errors;

  axi_cache_bridge_if #(.LINE_WORDS(4)) bus_if ();

  axi_cache_bridge #(.LINE_WORDS(4)) u_dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus_if)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // AR handshake followed by n R beats. Each beat's return-port signals are
  // checked against the expected source.
  task automatic run_read(input int n, input logic [31:0] base, input logic is_d);
    bus_if.arready = 1'b1;
    tick();
    bus_if.arready = 1'b0;
    check("ar_drop", 32'(bus_if.arvalid), 32'd0);
    check("rready_up", 32'(bus_if.rready), 32'd1);
    for (int i = 0; i < n; i++) begin
      bus_if.rvalid = 1'b1;
      bus_if.rdata  = base + 32'(i);
      bus_if.rlast  = (i == n - 1);
      #1;
      check("ret_valid", 32'(is_d ? bus_if.dcache_ret_valid : bus_if.icache_ret_valid), 32'd1);
      check("ret_other", 32'(is_d ? bus_if.icache_ret_valid : bus_if.dcache_ret_valid), 32'd0);
      check("ret_data", is_d ? bus_if.dcache_ret_data : bus_if.icache_ret_data, base + 32'(i));
      check("ret_last", 32'(is_d ? bus_if.dcache_ret_last : bus_if.icache_ret_last),
            32'(i == n - 1));
      tick();
    end
    bus_if.rvalid = 1'b0;
    bus_if.rlast  = 1'b0;
    check("rready_down", 32'(bus_if.rready), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  beat;
    bit  aw_done;
    bit  w_done;
    logic [31:0] exp_w [4];

    n_checks = 0;
    n_errors = 0;
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;

    aresetn = 1'b0;
    bus_if.arready = 1'b0; bus_if.rid = 4'd0; bus_if.rdata = 32'd0; bus_if.rresp = 2'd0;
    bus_if.rlast = 1'b0; bus_if.rvalid = 1'b0; bus_if.awready = 1'b0; bus_if.wready = 1'b0;
    bus_if.bid = 4'd0; bus_if.bresp = 2'd0; bus_if.bvalid = 1'b0;
    bus_if.icache_rd_req = 1'b0; bus_if.icache_rd_type = 3'd0; bus_if.icache_rd_addr = 32'd0;
    bus_if.dcache_rd_req = 1'b0; bus_if.dcache_rd_type = 3'd0; bus_if.dcache_rd_addr = 32'd0;
    bus_if.dcache_wr_req = 1'b0; bus_if.dcache_wr_type = 3'd0; bus_if.dcache_wr_addr = 32'd0;
    bus_if.dcache_wr_wstrb = 4'd0; bus_if.dcache_wr_data = '0;

    // ---------------- reset state ----------------
    tick(); tick();
    check("rst_arvalid", 32'(bus_if.arvalid), 32'd0);
    check("rst_rready", 32'(bus_if.rready), 32'd0);
    check("rst_awvalid", 32'(bus_if.awvalid), 32'd0);
    check("rst_wvalid", 32'(bus_if.wvalid), 32'd0);
    check("rst_bready", 32'(bus_if.bready), 32'd0);
    check("rst_wr_rdy", 32'(bus_if.dcache_wr_rdy), 32'd1);
    check("arburst", 32'(bus_if.arburst), 32'd1);
    check("awid", 32'(bus_if.awid), 32'd1);
    aresetn = 1'b1;
    tick();

    // ---------------- icache line read ----------------
    bus_if.icache_rd_req = 1'b1; bus_if.icache_rd_type = 3'b100;
    bus_if.icache_rd_addr = 32'h1C00_0040;
    #1;
    check("i_rdy", 32'(bus_if.icache_rd_rdy), 32'd1);
    tick();
    bus_if.icache_rd_req = 1'b0;
    check("i_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("i_araddr", bus_if.araddr, 32'h1C00_0040);
    check("i_arlen", 32'(bus_if.arlen), 32'd3);
    check("i_arsize", 32'(bus_if.arsize), 32'd2);
    check("i_arid", 32'(bus_if.arid), 32'd0);
    tick();
    check("ar_hold", 32'(bus_if.arvalid), 32'd1);
    check("ar_hold_addr", bus_if.araddr, 32'h1C00_0040);
    run_read(4, 32'hA0, 1'b0);

    // ---------------- simultaneous icache / dcache ----------------
    bus_if.icache_rd_req = 1'b1; bus_if.icache_rd_type = 3'b010;
    bus_if.icache_rd_addr = 32'h1000_0000;
    bus_if.dcache_rd_req = 1'b1; bus_if.dcache_rd_type = 3'b100;
    bus_if.dcache_rd_addr = 32'h2000_0040;
    #1;
    check("pri_d_rdy", 32'(bus_if.dcache_rd_rdy), 32'd1);
    check("pri_i_rdy", 32'(bus_if.icache_rd_rdy), 32'd0);
    tick();
    bus_if.dcache_rd_req = 1'b0;
    #1;
    check("pri_arid", 32'(bus_if.arid), 32'd1);
    check("pri_araddr", bus_if.araddr, 32'h2000_0040);
    check("pri_i_busy", 32'(bus_if.icache_rd_rdy), 32'd0);
    run_read(4, 32'hD0, 1'b1);
    check("pri_i_after", 32'(bus_if.icache_rd_rdy), 32'd1);
    tick();
    bus_if.icache_rd_req = 1'b0;
    check("i2_arid", 32'(bus_if.arid), 32'd0);
    check("i2_araddr", bus_if.araddr, 32'h1000_0000);
    check("i2_arlen", 32'(bus_if.arlen), 32'd0);
    run_read(1, 32'hC0, 1'b0);

    // ---------------- dcache line writeback ----------------
    bus_if.dcache_wr_req = 1'b1; bus_if.dcache_wr_type = 3'b100;
    bus_if.dcache_wr_addr = 32'h8000_1000; bus_if.dcache_wr_wstrb = 4'b0000;
    bus_if.dcache_wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
    #1;
    check("wb_rdy", 32'(bus_if.dcache_wr_rdy), 32'd1);
    tick();
    bus_if.dcache_wr_req = 1'b0;
    check("wb_awaddr", bus_if.awaddr, 32'h8000_1000);
    check("wb_awlen", 32'(bus_if.awlen), 32'd3);
    check("wb_awsize", 32'(bus_if.awsize), 32'd2);
    check("wb_rdy_busy", 32'(bus_if.dcache_wr_rdy), 32'd0);
    beat = 0; aw_done = 1'b0; w_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      check("wb_bready", 32'(bus_if.bready), 32'(aw_done && w_done));
      if (bus_if.bready) break;
      if (c <= 5) check("wb_aw_hold", 32'(bus_if.awvalid), 32'd1);
      bus_if.awready = (c >= 5);
      bus_if.wready  = (c % 2 == 1);
      #1;
      if (bus_if.awvalid && bus_if.awready) aw_done = 1'b1;
      if (bus_if.wvalid && bus_if.wready) begin
        check("wb_wdata", bus_if.wdata, exp_w[beat & 3]);
        check("wb_wstrb", 32'(bus_if.wstrb), 32'hF);
        check("wb_wlast", 32'(bus_if.wlast), 32'(beat == 3));
        if (beat == 3) w_done = 1'b1;
        beat++;
      end
      tick();
    end
    bus_if.awready = 1'b0; bus_if.wready = 1'b0;
    check("wb_beats", 32'(beat), 32'd4);
    check("wb_wvalid_off", 32'(bus_if.wvalid), 32'd0);
    bus_if.bvalid = 1'b1;
    tick();
    bus_if.bvalid = 1'b0;
    check("wb_bready_off", 32'(bus_if.bready), 32'd0);
    check("wb_rdy_back", 32'(bus_if.dcache_wr_rdy), 32'd1);

    // ---------------- byte write ----------------
    bus_if.dcache_wr_req = 1'b1; bus_if.dcache_wr_type = 3'b000;
    bus_if.dcache_wr_addr = 32'h8000_0003; bus_if.dcache_wr_wstrb = 4'b1000;
    bus_if.dcache_wr_data = {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
    tick();
    bus_if.dcache_wr_req = 1'b0;
    check("bw_awaddr", bus_if.awaddr, 32'h8000_0003);
    check("bw_awlen", 32'(bus_if.awlen), 32'd0);
    check("bw_awsize", 32'(bus_if.awsize), 32'd0);
    check("bw_wstrb", 32'(bus_if.wstrb), 32'h8);
    check("bw_wlast", 32'(bus_if.wlast), 32'd1);
    check("bw_wdata", bus_if.wdata, 32'hDEAD_BEEF);
    bus_if.awready = 1'b1; bus_if.wready = 1'b1;
    tick();
    bus_if.awready = 1'b0; bus_if.wready = 1'b0;
    check("bw_bready", 32'(bus_if.bready), 32'd1);
    check("bw_wvalid_off", 32'(bus_if.wvalid), 32'd0);
    bus_if.bvalid = 1'b1;
    tick();
    bus_if.bvalid = 1'b0;

    // ---------------- read-after-write hazard ----------------
    bus_if.dcache_wr_req = 1'b1; bus_if.dcache_wr_type = 3'b100;
    bus_if.dcache_wr_addr = 32'h8000_1000;
    bus_if.dcache_wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
    bus_if.dcache_rd_req = 1'b1; bus_if.dcache_rd_type = 3'b010;
    bus_if.dcache_rd_addr = 32'h8000_1008;
    #1;
    check("haz_accept", 32'(bus_if.dcache_rd_rdy), 32'd0);
    tick();
    bus_if.dcache_wr_req = 1'b0;
    check("haz_busy", 32'(bus_if.dcache_rd_rdy), 32'd0);
    bus_if.dcache_rd_addr = 32'h8000_2000;
    #1;
    check("haz_other_line", 32'(bus_if.dcache_rd_rdy), 32'd1);
    tick();
    bus_if.dcache_rd_req = 1'b0;
    check("haz_other_addr", bus_if.araddr, 32'h8000_2000);
    run_read(1, 32'h99, 1'b1);
    bus_if.dcache_rd_req = 1'b1; bus_if.dcache_rd_addr = 32'h8000_1008;
    #1;
    check("haz_still", 32'(bus_if.dcache_rd_rdy), 32'd0);
    bus_if.awready = 1'b1; bus_if.wready = 1'b1;
    tick(); tick(); tick(); tick();
    bus_if.awready = 1'b0; bus_if.wready = 1'b0;
    check("haz_bready", 32'(bus_if.bready), 32'd1);
    check("haz_resp", 32'(bus_if.dcache_rd_rdy), 32'd0);
    bus_if.bvalid = 1'b1;
    #1;
    check("haz_bvalid", 32'(bus_if.dcache_rd_rdy), 32'd0);
    tick();
    bus_if.bvalid = 1'b0;
    #1;
    check("haz_release", 32'(bus_if.dcache_rd_rdy), 32'd1);
    tick();
    bus_if.dcache_rd_req = 1'b0;
    check("haz_araddr", bus_if.araddr, 32'h8000_1008);
    run_read(1, 32'hBB, 1'b1);

    // ---------------- reset mid-transaction ----------------
    bus_if.icache_rd_req = 1'b1; bus_if.icache_rd_type = 3'b100;
    bus_if.icache_rd_addr = 32'h1C00_0080;
    tick();
    bus_if.icache_rd_req = 1'b0;
    bus_if.arready = 1'b1;
    tick();
    bus_if.arready = 1'b0;
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'h55; bus_if.rlast = 1'b0;
    tick();
    bus_if.rvalid = 1'b0;
    bus_if.dcache_wr_req = 1'b1; bus_if.dcache_wr_type = 3'b100;
    bus_if.dcache_wr_addr = 32'h8000_4000;
    tick();
    bus_if.dcache_wr_req = 1'b0;
    check("mid_rready", 32'(bus_if.rready), 32'd1);
    check("mid_wvalid", 32'(bus_if.wvalid), 32'd1);
    aresetn = 1'b0;
    bus_if.icache_rd_req = 1'b1; bus_if.icache_rd_type = 3'b010;
    bus_if.icache_rd_addr = 32'h3000_0000;
    tick();
    check("ar_rst_arvalid", 32'(bus_if.arvalid), 32'd0);
    check("ar_rst_rready", 32'(bus_if.rready), 32'd0);
    check("ar_rst_awvalid", 32'(bus_if.awvalid), 32'd0);
    check("ar_rst_wvalid", 32'(bus_if.wvalid), 32'd0);
    check("ar_rst_bready", 32'(bus_if.bready), 32'd0);
    check("ar_rst_wr_rdy", 32'(bus_if.dcache_wr_rdy), 32'd1);
    check("ar_rst_i_rdy", 32'(bus_if.icache_rd_rdy), 32'd1);
    aresetn = 1'b1;
    tick();
    bus_if.icache_rd_req = 1'b0;
    check("post_arvalid", 32'(bus_if.arvalid), 32'd1);
    check("post_araddr", bus_if.araddr, 32'h3000_0000);
    check("post_arlen", 32'(bus_if.arlen), 32'd0);
    run_read(1, 32'h77, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
